// File: rtl/rt_ibex_pcs_stack.sv
// ---------------------------------------------------------------------------
// rt_ibex_pcs_stack
//   Preemptible context-save LIFO for nested interrupts. Every taken interrupt
//   pushes a frame {irq level, saved registers}. Each mret pops the top frame
//   and pulses restore_en_o so the core can reload its register file.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   irq_ack_i         interrupt taken (1-cycle pulse), irq_level_i valid with it
//   store_data_i      flattened register values, valid the cycle after the ack
//   next_mret_i       next retiring instruction is mret (1-cycle pulse)
//   flush_i           drop every frame (applied in IDLE)
//   err_clr_i         clear the sticky overflow/underflow flags
//   restore_data_o    top-of-stack registers (0 when empty)
//   restore_level_o   top-of-stack level tag (0 when empty)
//   restore_en_o      one-cycle restore strobe
//   count_o, full_o, empty_o         occupancy status
//   overflow_o, underflow_o          sticky error flags
// ---------------------------------------------------------------------------
module rt_ibex_pcs_stack #(
    parameter int unsigned NrSavedRegs   = 9,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Depth         = 8,
    parameter int unsigned IrqLevelWidth = 8,
    parameter int unsigned CntWidth      = $clog2(Depth + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               irq_ack_i,
    input  logic [IrqLevelWidth-1:0]           irq_level_i,
    input  logic [NrSavedRegs*DataWidth-1:0]   store_data_i,
    input  logic                               next_mret_i,
    input  logic                               flush_i,
    input  logic                               err_clr_i,
    output logic [NrSavedRegs*DataWidth-1:0]   restore_data_o,
    output logic [IrqLevelWidth-1:0]           restore_level_o,
    output logic                               restore_en_o,
    output logic [CntWidth-1:0]                count_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic                               overflow_o,
    output logic                               underflow_o
);

    localparam int unsigned FrameWidth = NrSavedRegs * DataWidth;
    localparam int unsigned IdxWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CntWidth-1:0]        count_q, count_d;
    logic                       pending_q, pending_d;
    logic [IrqLevelWidth-1:0]   level_q, level_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;

    logic [FrameWidth-1:0]      data_mem_q  [Depth];
    logic [IrqLevelWidth-1:0]   level_mem_q [Depth];

    logic                       mem_we;
    logic [IdxWidth-1:0]        wr_idx;
    logic [IdxWidth-1:0]        top_idx;
    logic                       full;
    logic                       empty;

    assign full    = (count_q == CntFull);
    assign empty   = (count_q == '0);
    assign wr_idx  = IdxWidth'(count_q);
    // Only meaningful when not empty; outputs are forced to 0 otherwise.
    assign top_idx = IdxWidth'(count_q - CntOne);

    // State register and control flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Latched IRQ level and frame storage carry data only, so they are not reset.
    always_ff @(posedge clk_i) begin
        level_q <= level_d;
        if (mem_we) begin
            data_mem_q[wr_idx]  <= store_data_i;
            level_mem_q[wr_idx] <= level_q;
        end
    end

    // Next-state and control update
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_d   = pending_q;
        level_d     = level_q;
        // A set event later in this block overrides a same-cycle clear.
        overflow_d  = overflow_q & ~err_clr_i;
        underflow_d = underflow_q & ~err_clr_i;

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    count_d   = '0;
                    pending_d = 1'b0;
                end else if (irq_ack_i) begin
                    level_d = irq_level_i;
                    state_d = PUSH;
                    // mret racing the ack is served once the push is done.
                    if (next_mret_i) begin
                        pending_d = 1'b1;
                    end
                end else if (next_mret_i || pending_q) begin
                    state_d   = POP;
                    pending_d = 1'b0;
                end
            end
            PUSH: begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CntOne;
                end
                if (next_mret_i) begin
                    pending_d = 1'b1;
                end
                state_d = IDLE;
            end
            POP: begin
                if (empty) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - CntOne;
                end
                // An ack landing in POP pushes onto the already-decremented stack.
                if (irq_ack_i) begin
                    level_d = irq_level_i;
                    state_d = PUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mem_we       = (state_q == PUSH) && !full;
        restore_en_o = (state_q == POP) && !empty;
        if (empty) begin
            restore_data_o  = '0;
            restore_level_o = '0;
        end else begin
            restore_data_o  = data_mem_q[top_idx];
            restore_level_o = level_mem_q[top_idx];
        end
    end

    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
